// File: rtl/cpu_do_writer_pkg.sv
// Shared types and defaults for the Z80 data-out writer.
// Holds FSM/target encodings, default S-100 timing and small constant helpers.
package cpu_do_writer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        T_NONE,
        T_RAM,
        T_LED,
        T_S100IO,
        T_S100MEM
    } target_e;

    localparam int DEF_SETUP_CYCLES  = 2;
    localparam int DEF_STROBE_CYCLES = 4;
    localparam int DEF_HOLD_CYCLES   = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // A chip select only counts when the Z80 cycle type matches it.
    function automatic target_e pick_target(
        input logic is_mem,
        input logic is_io,
        input logic sel_ram,
        input logic sel_led,
        input logic sel_out,
        input logic sel_mem
    );
        if (is_mem && sel_ram) return T_RAM;
        if (is_io  && sel_led) return T_LED;
        if (is_io  && sel_out) return T_S100IO;
        if (is_mem && sel_mem) return T_S100MEM;
        return T_NONE;
    endfunction

endpackage

// File: rtl/cpu_do_writer_s100_write_timer.sv
// Loadable down-counter with a zero flag, shared by the S-100 setup/strobe/hold phases.
// Load takes effect on the next edge; decrement saturates at zero.
module cpu_do_writer_s100_write_timer #(
    parameter int CW = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic          zero_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/cpu_do_writer.sv
// Routes Z80 write data to on-chip RAM, the LED port, or a timed S-100 write cycle.
// On-chip targets complete in one clock; S-100 writes hold WAIT low for SETUP+STROBE+HOLD clocks.
module cpu_do_writer
    import cpu_do_writer_pkg::*;
#(
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] cpuDataOut,
    input  logic       cpu_mreq_n,
    input  logic       cpu_iorq_n,
    input  logic       cpu_wr_n,
    input  logic       ram_cs,
    input  logic       ledPort_cs,
    input  logic       outPort_cs,
    input  logic       s100Mem_cs,
    output logic [7:0] ramWriteData,
    output logic       ram_we,
    output logic [7:0] ledOut,
    output logic [7:0] s100DataOut,
    output logic       s100_sOUT,
    output logic       s100_sMWRT,
    output logic       s100_pWR,
    output logic       cpu_wait_n,
    output logic       busy
);

    localparam int CW = $clog2(max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES)) + 1;
    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);

    logic    wr_req;
    logic    wr_req_q;
    logic    trigger;
    target_e tgt;

    state_e  state_q, state_d;

    logic          tmr_load;
    logic          tmr_dec;
    logic [CW-1:0] tmr_val;
    logic          tmr_zero;

    logic [7:0] cap_dat_q, cap_dat_d;
    logic [7:0] led_q, led_d;
    logic [7:0] do_q, do_d;
    logic       ram_we_q, ram_we_d;
    logic       sout_q, sout_d;
    logic       smwrt_q, smwrt_d;
    logic       pwr_q, pwr_d;
    logic       wait_n_q, wait_n_d;

    assign wr_req  = !cpu_wr_n && (!cpu_mreq_n || !cpu_iorq_n);
    assign trigger = wr_req && !wr_req_q;
    assign tgt     = pick_target(!cpu_mreq_n, !cpu_iorq_n,
                                 ram_cs, ledPort_cs, outPort_cs, s100Mem_cs);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_req_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_req_q <= wr_req;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    case (tgt)
                        T_S100IO, T_S100MEM: begin
                            state_d  = SETUP;
                            tmr_load = 1'b1;
                            tmr_val  = SETUP_LD;
                        end
                        default: state_d = DONE;
                    endcase
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    state_d  = STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = STROBE_LD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            STROBE: begin
                if (tmr_zero) begin
                    state_d  = HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    state_d = DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DONE: begin
                // One action per Z80 write: wait for the request to drop before re-arming.
                if (!wr_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cap_dat_d = cap_dat_q;
        led_d     = led_q;
        do_d      = do_q;
        ram_we_d  = 1'b0;
        sout_d    = sout_q;
        smwrt_d   = smwrt_q;
        pwr_d     = pwr_q;
        wait_n_d  = wait_n_q;
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    cap_dat_d = cpuDataOut;
                    case (tgt)
                        T_RAM:     ram_we_d = 1'b1;
                        T_LED:     led_d    = cpuDataOut;
                        T_S100IO: begin
                            do_d     = cpuDataOut;
                            sout_d   = 1'b1;
                            wait_n_d = 1'b0;
                        end
                        T_S100MEM: begin
                            do_d     = cpuDataOut;
                            smwrt_d  = 1'b1;
                            wait_n_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            SETUP:  if (tmr_zero) pwr_d = 1'b1;
            STROBE: if (tmr_zero) pwr_d = 1'b0;
            HOLD: begin
                if (tmr_zero) begin
                    sout_d   = 1'b0;
                    smwrt_d  = 1'b0;
                    wait_n_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cap_dat_q <= 8'h00;
            led_q     <= 8'h00;
            do_q      <= 8'h00;
            ram_we_q  <= 1'b0;
            sout_q    <= 1'b0;
            smwrt_q   <= 1'b0;
            pwr_q     <= 1'b0;
            wait_n_q  <= 1'b1;
        end else begin
            cap_dat_q <= cap_dat_d;
            led_q     <= led_d;
            do_q      <= do_d;
            ram_we_q  <= ram_we_d;
            sout_q    <= sout_d;
            smwrt_q   <= smwrt_d;
            pwr_q     <= pwr_d;
            wait_n_q  <= wait_n_d;
        end
    end

    cpu_do_writer_s100_write_timer #(
        .CW (CW)
    ) u_s100_write_timer (
        .clock      (clock),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    assign ramWriteData = cap_dat_q;
    assign ram_we       = ram_we_q;
    assign ledOut       = led_q;
    assign s100DataOut  = do_q;
    assign s100_sOUT    = sout_q;
    assign s100_sMWRT   = smwrt_q;
    assign s100_pWR     = pwr_q;
    assign cpu_wait_n   = wait_n_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_cpu_do_writer.sv
// Bench for cpu_do_writer: default-timing instance A and 1/1/1-timing instance B share stimulus.
// A scoreboard of expected write actions is consumed by a monitor on the selected instance.
module tb_cpu_do_writer;

    localparam int A_SETUP = 2, A_STROBE = 4, A_HOLD = 2;
    localparam int B_SETUP = 1, B_STROBE = 1, B_HOLD = 1;
    localparam int K_RAM = 0, K_LED = 1, K_IO = 2, K_MEM = 3, K_NONE = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] cpuDataOut = 8'h00;
    logic       cpu_mreq_n = 1'b1, cpu_iorq_n = 1'b1, cpu_wr_n = 1'b1;
    logic       ram_cs = 1'b0, ledPort_cs = 1'b0, outPort_cs = 1'b0, s100Mem_cs = 1'b0;

    logic [7:0] a_rdat, a_led, a_do, b_rdat, b_led, b_do;
    logic       a_we, a_sout, a_smwrt, a_pwr, a_wait_n, a_busy;
    logic       b_we, b_sout, b_smwrt, b_pwr, b_wait_n, b_busy;

    always #5 clock = ~clock;

    cpu_do_writer #(
        .SETUP_CYCLES(A_SETUP), .STROBE_CYCLES(A_STROBE), .HOLD_CYCLES(A_HOLD)
    ) u_dut_a (
        .clock(clock), .reset(reset), .cpuDataOut(cpuDataOut),
        .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n), .cpu_wr_n(cpu_wr_n),
        .ram_cs(ram_cs), .ledPort_cs(ledPort_cs), .outPort_cs(outPort_cs), .s100Mem_cs(s100Mem_cs),
        .ramWriteData(a_rdat), .ram_we(a_we), .ledOut(a_led), .s100DataOut(a_do),
        .s100_sOUT(a_sout), .s100_sMWRT(a_smwrt), .s100_pWR(a_pwr),
        .cpu_wait_n(a_wait_n), .busy(a_busy)
    );

    cpu_do_writer #(
        .SETUP_CYCLES(B_SETUP), .STROBE_CYCLES(B_STROBE), .HOLD_CYCLES(B_HOLD)
    ) u_dut_b (
        .clock(clock), .reset(reset), .cpuDataOut(cpuDataOut),
        .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n), .cpu_wr_n(cpu_wr_n),
        .ram_cs(ram_cs), .ledPort_cs(ledPort_cs), .outPort_cs(outPort_cs), .s100Mem_cs(s100Mem_cs),
        .ramWriteData(b_rdat), .ram_we(b_we), .ledOut(b_led), .s100DataOut(b_do),
        .s100_sOUT(b_sout), .s100_sMWRT(b_smwrt), .s100_pWR(b_pwr),
        .cpu_wait_n(b_wait_n), .busy(b_busy)
    );

    logic       sel_b = 1'b0;
    logic [7:0] mon_rdat, mon_led, mon_do;
    logic       mon_we, mon_sout, mon_smwrt, mon_pwr, mon_wait_n, mon_busy;

    always_comb begin
        mon_rdat   = sel_b ? b_rdat   : a_rdat;
        mon_led    = sel_b ? b_led    : a_led;
        mon_do     = sel_b ? b_do     : a_do;
        mon_we     = sel_b ? b_we     : a_we;
        mon_sout   = sel_b ? b_sout   : a_sout;
        mon_smwrt  = sel_b ? b_smwrt  : a_smwrt;
        mon_pwr    = sel_b ? b_pwr    : a_pwr;
        mon_wait_n = sel_b ? b_wait_n : a_wait_n;
        mon_busy   = sel_b ? b_busy   : a_busy;
    end

    typedef struct {
        int         kind;
        logic [7:0] dat;
        int         wlen;
        int         poff;
        int         plen;
    } ev_t;

    ev_t sb[$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] d);
        ev_t e;
        int  s, st, h;
        s  = sel_b ? B_SETUP  : A_SETUP;
        st = sel_b ? B_STROBE : A_STROBE;
        h  = sel_b ? B_HOLD   : A_HOLD;
        e.kind = kind;
        e.dat  = d;
        e.wlen = s + st + h;
        e.poff = s;
        e.plen = st;
        sb.push_back(e);
    endtask

    task automatic sb_take(input int kind_obs, output ev_t e);
        check("sb_expected_event", sb.size() != 0, 1);
        if (sb.size() != 0) e = sb.pop_front();
        else e = '{kind: -1, dat: 8'h00, wlen: 0, poff: 0, plen: 0};
        check("event_kind", kind_obs, e.kind);
    endtask

    bit         in_seq = 1'b0;
    int         wlen, poff, plen;
    bit         o_io, o_mem, dat_ok;
    logic [7:0] o_dat;
    logic [7:0] prev_led = 8'h00;
    bit         prev_we = 1'b0;
    ev_t        mev;

    always @(negedge clock) begin
        if (reset) begin
            in_seq   = 1'b0;
            prev_led = 8'h00;
            prev_we  = 1'b0;
        end else begin
            check("status_excl_and_pwr_in_wait", {mon_sout & mon_smwrt, mon_pwr & mon_wait_n}, 0);
            check("ram_we_single_clock", prev_we & mon_we, 0);
            if (mon_we) begin
                sb_take(K_RAM, mev);
                check("ram_write_data", mon_rdat, mev.dat);
            end
            if (mon_led != prev_led) begin
                sb_take(K_LED, mev);
                check("led_data", mon_led, mev.dat);
            end
            if (!mon_wait_n) begin
                if (!in_seq) begin
                    in_seq = 1'b1;
                    wlen = 0; poff = -1; plen = 0;
                    o_io = mon_sout; o_mem = mon_smwrt; o_dat = mon_do; dat_ok = 1'b1;
                end
                wlen++;
                if (mon_pwr) begin
                    if (poff < 0) poff = wlen - 1;
                    plen++;
                end
                if (mon_do != o_dat || mon_sout != o_io || mon_smwrt != o_mem) dat_ok = 1'b0;
            end else if (in_seq) begin
                in_seq = 1'b0;
                sb_take(o_io ? K_IO : (o_mem ? K_MEM : K_NONE), mev);
                check("s100_data", o_dat, mev.dat);
                check("wait_low_clocks", wlen, mev.wlen);
                check("pwr_offset", poff, mev.poff);
                check("pwr_clocks", plen, mev.plen);
                check("s100_bus_stable", dat_ok, 1);
            end
            prev_we  = mon_we;
            prev_led = mon_led;
        end
    end

    task automatic drive_write(input bit io, input logic [7:0] d, input logic [3:0] cs);
        @(posedge clock); #1;
        cpuDataOut = d;
        cpu_mreq_n = io;
        cpu_iorq_n = !io;
        {ram_cs, ledPort_cs, outPort_cs, s100Mem_cs} = cs;
        cpu_wr_n = 1'b0;
    endtask

    task automatic release_bus();
        cpu_wr_n = 1'b1;
        cpu_mreq_n = 1'b1;
        cpu_iorq_n = 1'b1;
        {ram_cs, ledPort_cs, outPort_cs, s100Mem_cs} = 4'b0000;
    endtask

    // WR held for `hold` clocks; the data bus and selects are scrambled mid-cycle.
    task automatic z80_write(input bit io, input logic [7:0] d, input logic [3:0] cs, input int hold);
        drive_write(io, d, cs);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            if (i == 1) begin
                cpuDataOut = ~d;
                {ram_cs, ledPort_cs, outPort_cs, s100Mem_cs} = ~cs;
            end
        end
        check("busy_while_wr_held", mon_busy, 1);
        release_bus();
        for (int t = 0; t < 60; t++) begin
            @(negedge clock);
            if (!mon_busy) break;
        end
        check("returns_to_idle", mon_busy, 0);
        @(posedge clock);
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_data_outs", {a_rdat, a_led, a_do}, 24'h0);
        check("rst_strobes", {a_we, a_sout, a_smwrt, a_pwr, a_busy}, 5'b0);
        check("rst_wait_n", a_wait_n, 1);

        expect_ev(K_RAM, 8'hA5);
        z80_write(1'b0, 8'hA5, 4'b1000, 4);

        expect_ev(K_LED, 8'h3C);
        z80_write(1'b1, 8'h3C, 4'b0100, 6);

        expect_ev(K_IO, 8'h5A);
        z80_write(1'b1, 8'h5A, 4'b0010, 12);

        expect_ev(K_IO, 8'h81);
        z80_write(1'b1, 8'h81, 4'b0010, 2);

        z80_write(1'b1, 8'hEE, 4'b1000, 4);
        check("s100_do_holds_last", a_do, 8'h81);
        check("led_unchanged", a_led, 8'h3C);

        drive_write(1'b1, 8'h99, 4'b0010);
        t = 0;
        while (!a_pwr && t < 40) begin
            @(negedge clock);
            t++;
        end
        check("pwr_seen_before_reset", a_pwr, 1);
        @(posedge clock); #1;
        reset = 1'b1;
        release_bus();
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_mid_pwr_status", {a_pwr, a_sout, a_smwrt}, 3'b000);
        check("rst_mid_wait_n", a_wait_n, 1);
        check("rst_mid_led", a_led, 8'h00);
        check("rst_mid_busy", a_busy, 0);

        expect_ev(K_RAM, 8'h77);
        z80_write(1'b0, 8'h77, 4'b1000, 4);

        repeat (12) @(posedge clock);
        sel_b = 1'b1;
        @(posedge clock);

        expect_ev(K_MEM, 8'hC3);
        z80_write(1'b0, 8'hC3, 4'b0001, 6);

        expect_ev(K_RAM, 8'h1E);
        z80_write(1'b0, 8'h1E, 4'b1001, 4);

        repeat (5) @(posedge clock);
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
